// File: rtl/wide_add_pkg.sv
// Shared constants and state encoding for the nibble-serial adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: SLICE_W (datapath slice width), legacy state constants and the
// matching state enum used by wide_add_seq.
package wide_add_pkg;

  localparam int SLICE_W = 4;

  // Legacy-compatible encodings; the enum below reuses them so waveforms
  // and older tooling see the same values.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RUN  = S_RUN,
    DONE = S_DONE
  } state_e;

endpackage

// File: rtl/wide_add_seq_if.sv
// Operand/result handshake bundle for wide_add_seq.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
// Ports: in_valid, in_ready, a, b, cin, out_valid, out_ready, sum, cout, ovf,
// busy; plus sub when WIDE_ADD_SUB_EN is defined.
// Modports: slave = the adder, master = producer/consumer side.
interface wide_add_seq_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef WIDE_ADD_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport slave (
    input  in_valid,
    output in_ready,
    input  a,
    input  b,
    input  cin,
`ifdef WIDE_ADD_SUB_EN
    input  sub,
`endif
    output out_valid,
    input  out_ready,
    output sum,
    output cout,
    output ovf,
    output busy
  );

  modport master (
    output in_valid,
    input  in_ready,
    output a,
    output b,
    output cin,
`ifdef WIDE_ADD_SUB_EN
    output sub,
`endif
    input  out_valid,
    output out_ready,
    input  sum,
    input  cout,
    input  ovf,
    input  busy
  );

endinterface

// File: rtl/four_bit_RCA.sv
// 4-bit ripple-carry adder slice, purely combinational.
// Latency: 0 cycles (combinational).
// Backpressure: none (no handshake).
// Ports: a, b (4-bit operands), cin (carry in), sum (4-bit), cout (carry out).
module four_bit_RCA
  import wide_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SLICE_W];

endmodule

// File: rtl/wide_add_seq.sv
// WIDTH-bit adder built from one shared 4-bit slice, one nibble per cycle LSB first.
// Latency: out_valid rises NSLICE cycles after the accepting edge; one op per NSLICE+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Ports: clk, rst_n (async active-low), bus (wide_add_seq_if.slave: operand
// handshake a/b/cin, result handshake sum/cout/ovf, busy status).
// Optional: define WIDE_ADD_SUB_EN to add bus.sub, which turns the op into a-b.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic           clk,
  input logic           rst_n,
  wide_add_seq_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
    $error("wide_add_seq: WIDTH must be a multiple of 4 and at least 4");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  // Operand load values. Subtraction stores ~b and forces the initial carry,
  // so the datapath itself only ever adds.
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef WIDE_ADD_SUB_EN
  assign b_load = bus.sub ? ~bus.b : bus.b;
  assign c_load = bus.sub ? 1'b1   : bus.cin;
`else
  assign b_load = bus.b;
  assign c_load = bus.cin;
`endif

  // Shared slice: operands are muxed by the current nibble index.
  logic [SLICE_W-1:0] a_nib;
  logic [SLICE_W-1:0] b_nib;
  logic [SLICE_W-1:0] s_nib;
  logic               s_co;

  assign a_nib = a_q[SLICE_W*idx_q +: SLICE_W];
  assign b_nib = b_q[SLICE_W*idx_q +: SLICE_W];

  four_bit_RCA u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (c_q),
    .sum  (s_nib),
    .cout (s_co)
  );

  // Signed overflow on the last pass: like-signed operands producing a result
  // of the other sign. b_q already carries the inverted MSB when subtracting.
  logic ovf_next;
  assign ovf_next = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_nib[SLICE_W-1] != a_q[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= b_load;
            c_q     <= c_load;
            idx_q   <= '0;
            sum_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[SLICE_W*idx_q +: SLICE_W] <= s_nib;
          c_q <= s_co;
          if (idx_q == LAST_IDX) begin
            // idx stays on the last nibble so it never leaves 0..NSLICE-1.
            cout_q  <= s_co;
            ovf_q   <= ovf_next;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          // Only the result handshake completes here; a pending operand
          // is picked up next cycle from IDLE.
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed bench for wide_add_seq at WIDTH=16.
// Latency: checks out_valid exactly 4 cycles after accept.
// Backpressure: exercises held results, early out_ready and overlapping in_valid.
module tb_wide_add_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  wide_add_seq_if #(.WIDTH(16)) bus ();

  wide_add_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_sub(input logic s);
`ifdef WIDE_ADD_SUB_EN
    bus.sub = s;
`else
    if (s) $error("FAIL sub_request observed=1 expected=0");
`endif
  endtask

  // Presents one operation, checks latency and result, then drains it.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tcin, input logic tsub, input logic early_rdy,
                        input logic [15:0] esum, input logic ecout, input logic eovf);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_in_ready"}, bus.in_ready, 1);
    bus.a         = ta;
    bus.b         = tb_v;
    bus.cin       = tcin;
    set_sub(tsub);
    bus.in_valid  = 1'b1;
    bus.out_ready = early_rdy;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_latency"}, n, 4);
    check({tag, "_sum"}, bus.sum, esum);
    check({tag, "_cout"}, bus.cout, ecout);
    check({tag, "_ovf"}, bus.ovf, eovf);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, "_idle_after"}, bus.in_ready, 1);
    set_sub(1'b0);
  endtask

  initial begin
    int n;
    int seen;
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    set_sub(1'b0);

    // Reset state
    #12;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
    check("rst_ovf", bus.ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Main function
    run_op("basic",   16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("cin_rip", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    // out_ready already high during RUN must not shorten or skip DONE
    run_op("early_rdy", 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0);

    // Backpressure: hold result 3 cycles with new operands pending
    @(negedge clk);
    bus.a        = 16'h00FF;
    bus.b        = 16'h0001;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.a = 16'h0010;
    bus.b = 16'h0020;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_latency", n, 4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_sum", bus.sum, 16'h0100);
      check("bp_cout", bus.cout, 0);
      check("bp_ovf", bus.ovf, 0);
    end
    // in_valid and out_ready together in DONE: only the result completes
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp_hs_in_ready", bus.in_ready, 1);
    check("bp_hs_busy", bus.busy, 0);
    check("bp_hs_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp_next_busy", bus.busy, 1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp_next_latency", n, 4);
    check("bp_next_sum", bus.sum, 16'h0030);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;

    // Reset in the middle of RUN
    @(negedge clk);
    bus.a        = 16'hAAAA;
    bus.b        = 16'h5555;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_sum", bus.sum, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
      if (i == 0) check("post_rst_in_ready", bus.in_ready, 1);
    end
    check("post_rst_no_valid", seen, 0);
    run_op("post_rst", 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);

`ifdef WIDE_ADD_SUB_EN
    // cin is driven high to show it is ignored while subtracting
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
